// File: rtl/pipe_stage_reg.sv
//==============================================================================
// Module      : pipe_stage_reg
// Description : Parametrised inter-stage pipeline register (valid, PC, payload)
//               obeying the core stall vector with pass/hold/bubble and flush.
//               Optional performance counters: define PIPE_STAGE_PERF_CNT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pipe_stage_reg #(
  parameter int                 DATA_W   = 64,
  parameter int                 PC_W     = 32,
  parameter int                 STALL_W  = 6,
  parameter int                 STAGE    = 3,
  parameter logic [DATA_W-1:0]  NOP_DATA = '0,
  parameter int                 CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,        // asynchronous, active-low
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  output logic [PC_W-1:0]    out_pc,
  output logic [DATA_W-1:0]  out_data
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   hold_cnt,
  input  logic               cnt_clr
`endif
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } vstate_e;

  vstate_e           state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic w_us;
  logic w_ds;
  logic w_bubble;
  logic w_hold;
  logic w_stall_unused;

  assign w_us           = stall[STAGE];
  assign w_ds           = stall[STAGE+1];
  assign w_stall_unused = ^stall;

  // Flush outranks every stall combination; us=0/ds=1 falls through to pass.
  assign w_bubble = !flush && w_us && !w_ds;
  assign w_hold   = !flush && w_us && w_ds;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    data_d  = data_q;
    if (flush || w_bubble) begin
      state_d = ST_EMPTY;
      pc_d    = '0;
      data_d  = NOP_DATA;
    end else if (!w_hold) begin
      state_d = in_valid ? ST_FULL : ST_EMPTY;
      pc_d    = in_pc;
      data_d  = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      pc_q    <= '0;
      data_q  <= NOP_DATA;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_pc    = pc_q;
  assign out_data  = data_q;

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  // Saturating counters; clear wins over increment.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    if (cnt_clr) begin
      bubble_cnt_d = '0;
      hold_cnt_d   = '0;
    end else begin
      if (w_bubble && (bubble_cnt_q != {CNT_W{1'b1}}))
        bubble_cnt_d = bubble_cnt_q + 1'b1;
      if (w_hold && (hold_cnt_q != {CNT_W{1'b1}}))
        hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt_q <= '0;
      hold_cnt_q   <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign hold_cnt   = hold_cnt_q;
`endif

`ifndef SYNTHESIS
  // A legal stall controller never stalls downstream without stalling upstream.
  a_legal_stall: assert property (@(posedge clk) disable iff (!rst) !(!w_us && w_ds));
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
//==============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg against a reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pipe_stage_reg;

  localparam int          c_DATA_W  = 64;
  localparam int          c_PC_W    = 32;
  localparam int          c_STALL_W = 6;
  localparam int          c_STAGE   = 3;
  localparam int          c_CNT_W   = 4;
  localparam logic [63:0] c_NOP     = 64'h0000_0000_0000_00F0;
  localparam int          c_CNT_MAX = 15;

  logic                 clk;
  logic                 rst;
  logic [c_STALL_W-1:0] stall;
  logic                 flush;
  logic                 in_valid;
  logic [c_PC_W-1:0]    in_pc;
  logic [c_DATA_W-1:0]  in_data;
  logic                 out_valid;
  logic [c_PC_W-1:0]    out_pc;
  logic [c_DATA_W-1:0]  out_data;
  logic [c_CNT_W-1:0]   bubble_cnt;
  logic [c_CNT_W-1:0]   hold_cnt;
  logic                 cnt_clr;

  pipe_stage_reg #(
    .DATA_W   (c_DATA_W),
    .PC_W     (c_PC_W),
    .STALL_W  (c_STALL_W),
    .STAGE    (c_STAGE),
    .NOP_DATA (c_NOP),
    .CNT_W    (c_CNT_W)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_pc      (in_pc),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_data   (out_data)
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    .bubble_cnt (bubble_cnt),
    .hold_cnt   (hold_cnt),
    .cnt_clr    (cnt_clr)
`endif
  );

`ifndef PIPE_STAGE_PERF_CNT_EN
  assign bubble_cnt = '0;
  assign hold_cnt   = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic        m_valid;
  logic [31:0] m_pc;
  logic [63:0] m_data;
  int          m_bub;
  int          m_hold;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_pc    = '0;
    m_data  = c_NOP;
    m_bub   = 0;
    m_hold  = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, {63'd0, out_valid}, {63'd0, m_valid});
    check({tag, ".pc"},    {32'd0, out_pc},    {32'd0, m_pc});
    check({tag, ".data"},  out_data,           m_data);
`ifdef PIPE_STAGE_PERF_CNT_EN
    check({tag, ".bub"},   {60'd0, bubble_cnt}, 64'(m_bub));
    check({tag, ".hold"},  {60'd0, hold_cnt},   64'(m_hold));
`endif
  endtask

  // Advance one edge: apply the spec rules to the inputs seen at the edge,
  // then compare 1 time unit later.
  task automatic cycle(input string tag);
    logic us, ds, clr;
    @(posedge clk);
    us  = stall[c_STAGE];
    ds  = stall[c_STAGE+1];
`ifdef PIPE_STAGE_PERF_CNT_EN
    clr = cnt_clr;
`else
    clr = 1'b0;
`endif
    if (flush || (us && !ds)) begin
      if (!flush && !clr) m_bub = (m_bub < c_CNT_MAX) ? m_bub + 1 : m_bub;
      m_valid = 1'b0;
      m_pc    = '0;
      m_data  = c_NOP;
    end else if (us && ds) begin
      if (!clr) m_hold = (m_hold < c_CNT_MAX) ? m_hold + 1 : m_hold;
    end else begin
      m_valid = in_valid;
      m_pc    = in_pc;
      m_data  = in_data;
    end
    if (clr) begin
      m_bub  = 0;
      m_hold = 0;
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic [5:0] st, input logic fl, input logic v,
                       input logic [31:0] pc, input logic [63:0] d);
    stall    = st;
    flush    = fl;
    in_valid = v;
    in_pc    = pc;
    in_data  = d;
  endtask

  initial begin
    model_reset();
    rst = 1'b0;
    cnt_clr = 1'b0;
    drive(6'b0, 1'b0, 1'b0, '0, '0);
    #22;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // Directed pass / hold / bubble / flush
    drive(6'b000000, 1'b0, 1'b1, 32'h0040_0004, 64'h1234);
    cycle("pass");
    drive(6'b011000, 1'b0, 1'b1, 32'h0040_0008, 64'hAAAA);
    for (int i = 0; i < 3; i++) cycle("hold");
    check("hold_data", out_data, 64'h1234);
    drive(6'b001000, 1'b0, 1'b1, 32'h0040_000C, 64'hBBBB);
    cycle("bubble");
    check("bubble_valid", {63'd0, out_valid}, 64'd0);
    drive(6'b000000, 1'b0, 1'b1, 32'h0040_0010, 64'hCCCC);
    cycle("pass2");
    drive(6'b011000, 1'b1, 1'b1, 32'h0040_0014, 64'hDDDD);
    cycle("flush_hold");
    check("flush_data", out_data, c_NOP);
    drive(6'b000000, 1'b0, 1'b0, 32'h0040_0018, 64'hEEEE);
    cycle("pass_invalid");

    // Async reset between edges while FULL
    drive(6'b000000, 1'b0, 1'b1, 32'h0040_001C, 64'h5555);
    cycle("full");
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #1;
    rst = 1'b1;

`ifdef PIPE_STAGE_PERF_CNT_EN
    // Saturation of hold counter, then clear
    drive(6'b011000, 1'b0, 1'b1, 32'h1, 64'h1);
    for (int i = 0; i < 20; i++) cycle("sat");
    check("sat_hold", {60'd0, hold_cnt}, 64'd15);
    cnt_clr = 1'b1;
    cycle("clr");
    check("clr_hold", {60'd0, hold_cnt}, 64'd0);
    cnt_clr = 1'b0;
`endif

    // Randomised legal stall patterns
    for (int i = 0; i < 400; i++) begin
      logic [5:0] st;
      logic [1:0] sel;
      st  = 6'($urandom);
      sel = 2'($urandom_range(0, 2));
      st[c_STAGE]   = (sel != 2'd0);
      st[c_STAGE+1] = (sel == 2'd2);
      drive(st, ($urandom_range(0, 7) == 0), 1'($urandom),
            $urandom, {$urandom, $urandom});
`ifdef PIPE_STAGE_PERF_CNT_EN
      cnt_clr = ($urandom_range(0, 31) == 0);
`endif
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
